// File: rtl/axis_uart_fifo_transceiver.sv
// AXI-Stream UART transceiver with configurable framing and TX/RX FIFOs.
// Everything runs on aclk; uart_rx is brought in through a 2-FF synchroniser.

module axis_uart_fifo_transceiver_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             push;
  logic             pop;

  // Extra pointer MSB separates full from empty when the indices match.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end
endmodule

module axis_uart_fifo_transceiver #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 2,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       uart_rx,
  output logic       uart_tx,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       rx_done,
  output logic [1:0] rx_error,
  output logic       rx_overflow,
  output logic       tx_done
);
  localparam int             DIV         = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int             CW          = $clog2(DIV);
  localparam logic [CW-1:0]  RELOAD      = CW'(DIV - 1);
  localparam logic [CW-1:0]  HALF_RELOAD = CW'(DIV / 2 - 1);
  localparam logic [2:0]     LAST_BIT    = 3'(DATA_BITS - 1);
  localparam bit             HAS_PAR     = (PARITY != 0);
  localparam logic           ODD         = 1'(PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- TX path ----------------
  state_t                 tx_state_reg, tx_state_next;
  logic [CW-1:0]          tx_cnt_reg;
  logic [2:0]             tx_bit_reg;
  logic                   tx_stop_reg;
  logic [DATA_BITS-1:0]   tx_shift_reg;
  logic                   tx_par_reg;
  logic                   tx_tick;
  logic                   tx_last_stop;
  logic                   tx_pop;
  logic [DATA_BITS-1:0]   tx_fifo_data;
  logic                   tx_fifo_full;
  logic                   tx_fifo_empty;

  assign s_axis_tready = !tx_fifo_full && !areset;
  assign tx_tick       = (tx_cnt_reg == '0);
  assign tx_last_stop  = (tx_stop_reg == 1'(STOP_BITS - 1));

  axis_uart_fifo_transceiver_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .aclk    (aclk),
    .areset  (areset),
    .wr_en   (s_axis_tvalid && s_axis_tready),
    .wr_data (s_axis_tdata[DATA_BITS-1:0]),
    .rd_en   (tx_pop),
    .rd_data (tx_fifo_data),
    .full    (tx_fifo_full),
    .empty   (tx_fifo_empty)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      tx_state_reg <= S_IDLE;
      tx_cnt_reg   <= RELOAD;
      tx_bit_reg   <= '0;
      tx_stop_reg  <= 1'b0;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
    end else begin
      tx_state_reg <= tx_state_next;
      if (tx_pop) begin
        tx_shift_reg <= tx_fifo_data;
        tx_par_reg   <= ^tx_fifo_data ^ ODD;
        tx_cnt_reg   <= RELOAD;
        tx_bit_reg   <= '0;
        tx_stop_reg  <= 1'b0;
      end else if (tx_state_reg != S_IDLE) begin
        if (tx_tick) begin
          tx_cnt_reg <= RELOAD;
          if (tx_state_reg == S_DATA) begin
            tx_shift_reg <= tx_shift_reg >> 1;
            tx_bit_reg   <= tx_bit_reg + 3'd1;
          end
          if (tx_state_reg == S_STOP) tx_stop_reg <= 1'b1;
        end else begin
          tx_cnt_reg <= tx_cnt_reg - CW'(1);
        end
      end
    end
  end

  // The last stop cycle pops the next entry directly so frames abut.
  always_comb begin
    tx_state_next = tx_state_reg;
    tx_pop        = 1'b0;
    case (tx_state_reg)
      S_IDLE: begin
        if (!tx_fifo_empty) begin
          tx_pop        = 1'b1;
          tx_state_next = S_START;
        end
      end
      S_START:  if (tx_tick) tx_state_next = S_DATA;
      S_DATA:   if (tx_tick && tx_bit_reg == LAST_BIT) tx_state_next = HAS_PAR ? S_PARITY : S_STOP;
      S_PARITY: if (tx_tick) tx_state_next = S_STOP;
      S_STOP: begin
        if (tx_tick && tx_last_stop) begin
          if (!tx_fifo_empty) begin
            tx_pop        = 1'b1;
            tx_state_next = S_START;
          end else begin
            tx_state_next = S_IDLE;
          end
        end
      end
      default: tx_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    uart_tx = 1'b1;
    tx_done = 1'b0;
    case (tx_state_reg)
      S_START:  uart_tx = 1'b0;
      S_DATA:   uart_tx = tx_shift_reg[0];
      S_PARITY: uart_tx = tx_par_reg;
      S_STOP:   tx_done = tx_tick && tx_last_stop;
      default:  uart_tx = 1'b1;
    endcase
  end

  // ---------------- RX path ----------------
  logic                   rx_s1_reg, rx_s2_reg, rx_s3_reg;
  state_t                 rx_state_reg, rx_state_next;
  logic [CW-1:0]          rx_cnt_reg;
  logic [2:0]             rx_bit_reg;
  logic [DATA_BITS-1:0]   rx_shift_reg;
  logic                   rx_perr_reg;
  logic                   rx_tick;
  logic                   rx_fall;
  logic [DATA_BITS-1:0]   rx_fifo_data;
  logic                   rx_fifo_full;
  logic                   rx_fifo_empty;

  assign rx_tick = (rx_cnt_reg == '0);
  assign rx_fall = rx_s3_reg && !rx_s2_reg;

  always_ff @(posedge aclk) begin
    if (areset) begin
      rx_s1_reg <= 1'b1;
      rx_s2_reg <= 1'b1;
      rx_s3_reg <= 1'b1;
    end else begin
      rx_s1_reg <= uart_rx;
      rx_s2_reg <= rx_s1_reg;
      rx_s3_reg <= rx_s2_reg;
    end
  end

  axis_uart_fifo_transceiver_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .aclk    (aclk),
    .areset  (areset),
    .wr_en   (rx_done && !rx_fifo_full),
    .wr_data (rx_shift_reg),
    .rd_en   (m_axis_tvalid && m_axis_tready),
    .rd_data (rx_fifo_data),
    .full    (rx_fifo_full),
    .empty   (rx_fifo_empty)
  );

  // IDLE keeps the counter preloaded with a half bit so START samples mid-bit.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rx_state_reg <= S_IDLE;
      rx_cnt_reg   <= HALF_RELOAD;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_perr_reg  <= 1'b0;
    end else begin
      rx_state_reg <= rx_state_next;
      if (rx_state_reg == S_IDLE) begin
        rx_cnt_reg  <= HALF_RELOAD;
        rx_bit_reg  <= '0;
        rx_perr_reg <= 1'b0;
      end else if (rx_tick) begin
        rx_cnt_reg <= RELOAD;
        if (rx_state_reg == S_DATA) begin
          rx_shift_reg <= {rx_s2_reg, rx_shift_reg[DATA_BITS-1:1]};
          rx_bit_reg   <= rx_bit_reg + 3'd1;
        end
        if (rx_state_reg == S_PARITY) rx_perr_reg <= rx_s2_reg ^ (^rx_shift_reg) ^ ODD;
      end else begin
        rx_cnt_reg <= rx_cnt_reg - CW'(1);
      end
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    case (rx_state_reg)
      S_IDLE:   if (rx_fall) rx_state_next = S_START;
      S_START:  if (rx_tick) rx_state_next = rx_s2_reg ? S_IDLE : S_DATA;
      S_DATA:   if (rx_tick && rx_bit_reg == LAST_BIT) rx_state_next = HAS_PAR ? S_PARITY : S_STOP;
      S_PARITY: if (rx_tick) rx_state_next = S_STOP;
      S_STOP:   if (rx_tick) rx_state_next = S_IDLE;
      default:  rx_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_done       = (rx_state_reg == S_STOP) && rx_tick;
    rx_error      = rx_done ? {!rx_s2_reg, rx_perr_reg} : 2'b00;
    rx_overflow   = rx_done && rx_fifo_full;
    m_axis_tvalid = !rx_fifo_empty;
    m_axis_tdata  = m_axis_tvalid ? 8'(rx_fifo_data) : 8'h00;
  end
endmodule

// File: tb/tb_axis_uart_fifo_transceiver.sv
// Directed bench: 8E1 instance at DIV=10 plus a 7O2 loopback instance at DIV=8.

module tb_axis_uart_fifo_transceiver;
  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = 10;
  localparam int HALF     = DIV / 2;
  localparam int V_BAUD   = 125_000;

  logic       aclk = 1'b0;
  logic       areset;
  logic       uart_rx, uart_tx;
  logic [7:0] s_tdata, m_tdata;
  logic       s_tvalid, s_tready, m_tvalid, m_tready;
  logic       rx_done, rx_overflow, tx_done;
  logic [1:0] rx_error;

  logic       v_uart_tx;
  logic [7:0] v_s_tdata, v_m_tdata;
  logic       v_s_tvalid, v_s_tready, v_m_tvalid;
  logic       v_rx_done, v_rx_overflow, v_tx_done;
  logic [1:0] v_rx_error;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int rx_fall_cyc = 0;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  axis_uart_fifo_transceiver #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) dut (
    .aclk(aclk), .areset(areset), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .rx_done(rx_done), .rx_error(rx_error), .rx_overflow(rx_overflow), .tx_done(tx_done)
  );

  axis_uart_fifo_transceiver #(
    .CLK_FREQ(CLK_FREQ), .BAUD(V_BAUD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(16)
  ) dut_v (
    .aclk(aclk), .areset(areset), .uart_rx(v_uart_tx), .uart_tx(v_uart_tx),
    .s_axis_tdata(v_s_tdata), .s_axis_tvalid(v_s_tvalid), .s_axis_tready(v_s_tready),
    .m_axis_tdata(v_m_tdata), .m_axis_tvalid(v_m_tvalid), .m_axis_tready(1'b1),
    .rx_done(v_rx_done), .rx_error(v_rx_error), .rx_overflow(v_rx_overflow), .tx_done(v_tx_done)
  );

  typedef struct {
    logic [7:0]  d;
    logic [10:0] frame;   // bit i is the i-th bit on the line: {stop, parity, data, start}
  } tx_vec_t;

  typedef struct {
    logic [7:0] d;
    bit         flip_par;
    bit         stop_low;
    logic [1:0] exp_err;
    logic [7:0] exp_data;
  } rx_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic tx_one(input logic [7:0] d, input logic [10:0] exp);
    logic [10:0] got;
    int s_cyc;
    int n;
    got = '0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    check("tx_tready", s_tready, 1);
    tick(1);
    s_tvalid = 1'b0;
    check("tx_idle_n1", uart_tx, 1);
    tick(1);
    check("tx_start_n2", uart_tx, 0);
    s_cyc = cyc;
    tick(HALF);
    for (int i = 0; i < 11; i++) begin
      got[i] = uart_tx;
      if (i < 10) tick(DIV);
    end
    check("tx_frame", got, exp);
    n = 0;
    while (tx_done !== 1'b1 && n < 2 * DIV) begin
      tick(1);
      n++;
    end
    check("tx_done_cycle", cyc - s_cyc, 11 * DIV - 1);
    tick(1);
    check("tx_done_pulse", tx_done, 0);
    $display("tx %02h frame %03h", d, got);
  endtask

  task automatic tx_capture(output logic [10:0] fr, output int st);
    int n;
    n = 0;
    fr = '0;
    while (uart_tx !== 1'b0 && n < 400) begin
      tick(1);
      n++;
    end
    check("tx_capture_start", (n < 400), 1);
    st = cyc;
    tick(HALF);
    for (int i = 0; i < 11; i++) begin
      fr[i] = uart_tx;
      if (i < 10) tick(DIV);
    end
  endtask

  task automatic rx_send(input logic [7:0] d, input bit flip_par, input bit stop_low);
    logic [10:0] fr;
    fr = {~stop_low, (^d) ^ flip_par, d, 1'b0};
    rx_fall_cyc = cyc;
    for (int i = 0; i < 11; i++) begin
      uart_rx = fr[i];
      tick(DIV);
    end
    uart_rx = 1'b1;
    tick(2 * DIV);
  endtask

  task automatic rx_wait(input logic [1:0] exp_err, input bit exp_ovf);
    int n;
    n = 0;
    while (rx_done !== 1'b1 && n < 300) begin
      tick(1);
      n++;
    end
    check("rx_done_seen", rx_done, 1);
    check("rx_latency", cyc - rx_fall_cyc, 2 + HALF + 10 * DIV);
    check("rx_error", rx_error, exp_err);
    check("rx_overflow", rx_overflow, exp_ovf);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tx_vec_t     tx_vecs[7];
    rx_vec_t     rx_vecs[6];
    logic [7:0]  b2b[20];
    int          lows;

    tx_vecs[0] = '{8'hA5, {1'b1, 1'b0, 8'hA5, 1'b0}};
    tx_vecs[1] = '{8'h00, {1'b1, 1'b0, 8'h00, 1'b0}};
    tx_vecs[2] = '{8'hFF, {1'b1, 1'b0, 8'hFF, 1'b0}};
    tx_vecs[3] = '{8'h01, {1'b1, 1'b1, 8'h01, 1'b0}};
    tx_vecs[4] = '{8'h80, {1'b1, 1'b1, 8'h80, 1'b0}};
    tx_vecs[5] = '{8'h7F, {1'b1, 1'b1, 8'h7F, 1'b0}};
    tx_vecs[6] = '{8'h6E, {1'b1, 1'b1, 8'h6E, 1'b0}};

    rx_vecs[0] = '{8'h3C, 1'b0, 1'b0, 2'd0, 8'h3C};
    rx_vecs[1] = '{8'h3C, 1'b1, 1'b0, 2'd1, 8'h3C};
    rx_vecs[2] = '{8'h3C, 1'b0, 1'b1, 2'd2, 8'h3C};
    rx_vecs[3] = '{8'h00, 1'b0, 1'b0, 2'd0, 8'h00};
    rx_vecs[4] = '{8'hFF, 1'b0, 1'b0, 2'd0, 8'hFF};
    rx_vecs[5] = '{8'hA5, 1'b1, 1'b1, 2'd3, 8'hA5};

    for (int i = 0; i < 20; i++) b2b[i] = 8'($urandom_range(0, 255));

    areset = 1'b1; uart_rx = 1'b1; s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b0;
    v_s_tdata = '0; v_s_tvalid = 1'b0;
    tick(3);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_tready", s_tready, 0);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_rx_done", rx_done, 0);
    check("rst_rx_error", rx_error, 0);
    check("rst_rx_overflow", rx_overflow, 0);
    check("rst_tx_done", tx_done, 0);
    areset = 1'b0;
    tick(1);
    check("rst_tready_after", s_tready, 1);
    check("rst_v_tready_after", v_s_tready, 1);

    for (int i = 0; i < 7; i++) tx_one(tx_vecs[i].d, tx_vecs[i].frame);

    // One byte is popped straight away, so 17 are accepted before the FIFO fills.
    fork
      begin
        int acc;
        int acc_at_full;
        int t;
        acc = 0; acc_at_full = -1; t = 0;
        s_tvalid = 1'b1;
        s_tdata  = b2b[0];
        while (acc < 20 && t < 5000) begin
          if (s_tready) begin
            tick(1);
            acc++;
            if (acc < 20) s_tdata = b2b[acc];
          end else begin
            if (acc_at_full < 0) acc_at_full = acc;
            tick(1);
          end
          t++;
        end
        s_tvalid = 1'b0;
        check("b2b_accept_before_full", acc_at_full, 17);
        check("b2b_all_accepted", acc, 20);
      end
      begin
        logic [10:0] fr;
        int st;
        int prev;
        prev = 0;
        for (int k = 0; k < 20; k++) begin
          tx_capture(fr, st);
          check("b2b_frame", fr, {1'b1, ^b2b[k], b2b[k], 1'b0});
          if (k > 0) check("b2b_gap", st - prev, 11 * DIV);
          prev = st;
          $display("b2b %0d data %02h frame %03h", k, b2b[k], fr);
        end
      end
    join
    tick(2 * DIV);

    uart_rx = 1'b0;
    tick(HALF - 2);
    uart_rx = 1'b1;
    lows = 0;
    repeat (200) begin
      tick(1);
      if (rx_done) lows++;
    end
    check("glitch_no_done", lows, 0);
    $display("glitch rx_done count %0d", lows);

    for (int i = 0; i < 6; i++) begin
      fork
        rx_send(rx_vecs[i].d, rx_vecs[i].flip_par, rx_vecs[i].stop_low);
        begin
          rx_wait(rx_vecs[i].exp_err, 1'b0);
          check("rx_tvalid_at_done", m_tvalid, 0);
          tick(1);
          check("rx_done_pulse", rx_done, 0);
          check("rx_tvalid_after", m_tvalid, 1);
          check("rx_tdata", m_tdata, rx_vecs[i].exp_data);
          $display("rx %02h err %0d data %02h", rx_vecs[i].d, rx_vecs[i].exp_err, m_tdata);
          m_tready = 1'b1;
          tick(1);
          m_tready = 1'b0;
          check("rx_drained", m_tvalid, 0);
        end
      join
    end

    for (int k = 0; k < 17; k++) begin
      fork
        rx_send(8'(8'h40 + k), 1'b0, 1'b0);
        rx_wait(2'd0, (k == 16));
      join
      $display("ovf frame %0d sent", k + 1);
    end
    for (int k = 0; k < 16; k++) begin
      check("ovf_drain_valid", m_tvalid, 1);
      check("ovf_drain_data", m_tdata, 8'(8'h40 + k));
      m_tready = 1'b1;
      tick(1);
      m_tready = 1'b0;
    end
    check("ovf_drain_empty", m_tvalid, 0);

    fork
      rx_send(8'h5A, 1'b0, 1'b0);
      rx_wait(2'd0, 1'b0);
    join
    check("rst_pre_tvalid", m_tvalid, 1);
    s_tdata  = 8'h00;
    s_tvalid = 1'b1;
    tick(2);
    s_tvalid = 1'b0;
    tick(3 * DIV);
    check("rst_pre_tx_low", uart_tx, 0);
    areset = 1'b1;
    tick(1);
    check("rst_mid_uart_tx", uart_tx, 1);
    check("rst_mid_tvalid", m_tvalid, 0);
    check("rst_mid_tdata", m_tdata, 0);
    check("rst_mid_tready", s_tready, 0);
    areset = 1'b0;
    tick(1);
    check("rst_mid_tready_after", s_tready, 1);
    lows = 0;
    repeat (30 * DIV) begin
      tick(1);
      if (uart_tx !== 1'b1 || m_tvalid !== 1'b0) lows++;
    end
    check("rst_fifos_flushed", lows, 0);
    $display("reset mid-frame: idle violations %0d", lows);

    fork
      begin
        for (int k = 0; k < 128; k++) begin
          int n;
          n = 0;
          v_s_tdata  = 8'(k);
          v_s_tvalid = 1'b1;
          while (v_s_tready !== 1'b1 && n < 2000) begin
            tick(1);
            n++;
          end
          tick(1);
        end
        v_s_tvalid = 1'b0;
      end
      begin
        int got;
        int t;
        got = 0; t = 0;
        while (got < 128 && t < 20000) begin
          tick(1);
          t++;
          if (v_rx_done) check("var_rx_error", v_rx_error, 0);
          if (v_m_tvalid) begin
            check("var_data", v_m_tdata, {1'b0, 7'(got)});
            $display("var rx %02h expected %02h", v_m_tdata, {1'b0, 7'(got)});
            got++;
          end
        end
        check("var_count", got, 128);
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_uart_fifo_transceiver.md
# axis_uart_fifo_transceiver

Parametrised AXI-Stream UART transceiver, successor to the fixed 8N1+parity transceiver. It adds configurable data width, parity mode, stop bits, baud rate and RX/TX FIFOs with overflow reporting. It sits between the system AXI-Stream fabric (s_axis for TX bytes, m_axis for RX bytes) and the external UART pins, and it runs entirely in the aclk domain.

## Interface
- CLK_FREQ, 100_000_000: aclk frequency, Hz.
- BAUD, 115200: line rate. DIV = round(CLK_FREQ/BAUD) cycles per bit (868 at defaults).
- DATA_BITS, 8: payload bits per frame. Legal range 5..8.
- PARITY, 2: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: depth of each FIFO. Must be a power of two, ≥ 2.
- aclk  in  1  clock; all logic is on its rising edge.
- areset  in  1  synchronous, active-high reset.
- uart_rx  in  1  asynchronous serial input; idle high.
- uart_tx  out  1  serial output; idle high.
- s_axis  axis_if slave  tdata[7:0]/tvalid/tready  TX bytes. Only tdata[DATA_BITS-1:0] is used.
- m_axis  axis_if master  tdata[7:0]/tvalid/tready  RX bytes, right-justified; upper bits are 0.
- rx_done  out  1  one-cycle pulse when an RX frame completes, error-free or not.
- rx_error  out  2  valid only during rx_done. Bit 0 = parity error, bit 1 = frame error (first stop bit sampled low).
- rx_overflow  out  1  one-cycle pulse when a completed frame is dropped because the RX FIFO is full.
- tx_done  out  1  one-cycle pulse at the end of the last stop bit.

## Operation
- **TX path**
  - s_axis.tready = !tx_fifo_full. A byte is written when tvalid && tready.
  - TX FSM states: IDLE → START → DATA → PARITY → STOP → IDLE.
  - In IDLE with the FIFO non-empty, the FSM pops one entry and enters START.
  - START drives 0 for DIV cycles.
  - DATA drives DATA_BITS bits, LSB first, DIV cycles each.
  - PARITY drives XOR of the data for even parity, or its inverse for odd parity. The state is skipped when PARITY=0.
  - STOP drives 1 for STOP_BITS×DIV cycles, then asserts tx_done.
  - Back-to-back frames: the next START begins the cycle after tx_done. The line has no extra idle time.
- **RX path**
  - uart_rx passes through a 2-FF synchroniser.
  - RX FSM states: IDLE → START → DATA → PARITY → STOP → IDLE.
  - IDLE: a synchronised falling edge moves the FSM to START and clears the bit counter.
  - START: the line is sampled at DIV/2. If it is high, this is a false start: return to IDLE with no pulse.
  - DATA: bits are sampled every DIV cycles after the start sample, then shifted LSB first.
  - PARITY is sampled when PARITY≠0 and compared with the received data.
  - STOP: only the first stop bit is sampled. A receiver in IDLE re-arms on the next falling edge, whatever STOP_BITS is.
- **RX completion:** on the first stop-bit sample, rx_done pulses and rx_error reports the result.
  - If the RX FIFO is not full, the byte is written. Bytes with errors are written too; software filters them using rx_error.
  - If the RX FIFO is full, the byte is discarded and rx_overflow pulses in the same cycle as rx_done.
- **RX output:** m_axis.tvalid = !rx_fifo_empty and the FIFO is first-word-fall-through. tdata holds stable while tvalid && !tready.
- **FIFOs**
  - Circular buffers with log2(FIFO_DEPTH)+1-bit pointers. Full and empty are distinguished by the pointer MSB, and the pointers wrap modulo 2×FIFO_DEPTH.
  - A simultaneous push and pop while full is not allowed: tready is low when full.
  - A simultaneous push and pop while non-empty leaves the level unchanged.

## Timing
- **Reset values:** uart_tx=1; s_axis.tready=0 during reset and 1 the cycle after; m_axis.tvalid=0; m_axis.tdata=0; rx_done, rx_error, rx_overflow and tx_done all 0; FIFOs empty; both FSMs in IDLE.
- **Reset mid-frame:** uart_tx returns to 1 the cycle after areset is sampled. Both partial frames and all FIFO contents are lost.
- **TX latency:** the s_axis handshake at cycle N puts the start bit on uart_tx at N+2 (FIFO write, then FSM pop), provided TX is idle.
- **TX frame length:** (1 + DATA_BITS + (PARITY≠0) + STOP_BITS)×DIV cycles from the start edge to tx_done, inclusive.
- **RX latency:** rx_done is at 2 (synchroniser) + DIV/2 + (DATA_BITS + (PARITY≠0) + 1)×DIV cycles after the uart_rx falling edge.
  - m_axis.tvalid rises one cycle after rx_done if the FIFO was empty.
- **Baud counter:** reloads to DIV−1 and counts down. The bit boundary is at count 0. RX and TX use independent counters.
- **Tolerance:** the receiver accepts frames with up to ±2 % baud mismatch.

## Test plan
- **Even-parity TX (defaults):** write 0xA5 on s_axis. Required uart_tx sequence is 0, 1,0,1,0,0,1,0,1, parity 0, stop 1, each 868 cycles, then a tx_done pulse.
- **Back-to-back TX:** write 20 random bytes with tvalid held high. tready drops after 16 outstanding bytes, and all 20 bytes appear in order with no gap between frames.
- **RX error check:** send 0x3C, then 0x3C with the parity bit flipped, then 0x3C with the stop bit low. Required: m_axis delivers 0x3C three times; rx_error = 0, 1, 2 at the respective rx_done pulses.
- **RX overflow:** hold m_axis.tready=0 and send 17 frames. The first 16 are buffered and rx_overflow pulses on frame 17. Draining yields frames 1..16 only.
- **Glitch and reset:** a 300-cycle low glitch on uart_rx produces no rx_done. Asserting areset mid-TX-frame forces uart_tx=1 the next cycle and m_axis.tvalid=0.
- **Variant build:** DATA_BITS=7, PARITY=1, STOP_BITS=2, BAUD=921600 (DIV=109). Loop uart_tx to uart_rx and send 0x00..0x7F. Required: all 128 values are received intact with rx_error=0.
